sram_mem_stage: RTL and testbench
=================================

# sram_mem_stage

Memory-stage access unit placed directly after the EX/MEM pipeline register. It takes that register's `mem_read`, `mem_write`, `alu_result` (address) and `val_Rm` (store data) outputs. Each 32-bit load or store is performed as two sequential 16-bit accesses to an external SRAM. While an access is in progress, `ready` is held low so the pipeline freezes; `read_data` feeds the MEM/WB register.

## Interface
- `SRAM_WAIT`, 2: cycles spent on each 16-bit half-access; legal range 2..15.
- `ADDR_BASE`, 32'd1024: byte address that maps to SRAM word 0.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `mem_read` in 1: load request from the EX/MEM register.
- `mem_write` in 1: store request from the EX/MEM register.
- `address` in 32: byte address (ALU result).
- `write_data` in 32: store data (val_Rm).
- `read_data` out 32: load result, registered.
- `ready` out 1: 1 means the pipeline may advance; 0 means freeze.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: SRAM write data.
- `sram_dq_oe` out 1: SRAM data bus drive enable.
- `sram_we_n` out 1: SRAM write strobe, active-low.
- `sram_dq_in` in 16: SRAM read data.

## Operation
- States:
  - IDLE: no access in progress.
  - LOW: half-word 0, which holds bits [15:0].
  - HIGH: half-word 1, which holds bits [31:16].
  - DONE: one cycle in which the result is presented.
- Cycle counter `cnt` (4 bits) counts 0..SRAM_WAIT-1 within LOW and HIGH.
- Request = `mem_read | mem_write`. If both are set, the write wins: the access is a store and `read_data` is unchanged.
- IDLE, request present:
  - Latch op, word address and write data.
  - Next state is LOW with `cnt` = 0.
- IDLE, no request: stay in IDLE.
- Word address: wa = (address − ADDR_BASE) mod 2^32, then take bits [18:2].
  - LOW drives `sram_addr` = {wa[16:0],0}.
  - HIGH drives `sram_addr` = {wa[16:0],1}.
  - `address[1:0]` is ignored.
- LOW/HIGH:
  - Increment `cnt` each cycle.
  - At `cnt` = SRAM_WAIT-1: reset `cnt` to 0 and advance LOW→HIGH or HIGH→DONE.
- Store:
  - `sram_dq_oe` = 1 throughout LOW and HIGH.
  - `sram_dq_out` = latched data [15:0] in LOW and [31:16] in HIGH.
  - `sram_we_n` = 0 when `cnt` < SRAM_WAIT-1, and 1 on the last cycle of each half, so the address is stable around the strobe edges.
- Load:
  - `sram_we_n` = 1 and `sram_dq_oe` = 0.
  - On the last cycle of LOW, capture `sram_dq_in` into `read_data[15:0]`.
  - On the last cycle of HIGH, capture `sram_dq_in` into `read_data[31:16]`.
- DONE: `ready` = 1 and `read_data` holds the full word. Next state is IDLE unconditionally.
- `ready` (combinational):
  - 1 in IDLE when there is no request.
  - 1 in DONE.
  - 0 otherwise, including the IDLE cycle in which a request first appears.
- `read_data` keeps the last completed load value until the next load completes.
- In IDLE and DONE: `sram_we_n` = 1, `sram_dq_oe` = 0, and `sram_addr`/`sram_dq_out` hold their previous values.

## Timing
- Reset (synchronous, on a `clk` edge with `rst` = 1):
  - State → IDLE, `cnt` = 0.
  - `read_data` = 0, `sram_addr` = 0, `sram_dq_out` = 0.
  - `sram_dq_oe` = 0, `sram_we_n` = 1.
  - `ready` then follows the IDLE rule.
- Reset mid-access: the access is abandoned on that edge with no further strobes; the partial `read_data` is cleared to 0.
- With a request first visible in cycle 0:
  - LOW occupies cycles 1..W.
  - HIGH occupies cycles W+1..2W.
  - DONE is cycle 2W+1.
  - `ready` is low in cycles 0..2W: 2W+1 freeze cycles, 5 for W=2.
- While frozen, the EX/MEM register holds its inputs stable; the block does not re-sample them after latching in cycle 0.
- Back-to-back: a request present in the cycle after DONE starts in IDLE like cycle 0. There is no zero-gap issue.
- `read_data` changes only on capture edges inside LOW/HIGH, or on reset.

## Test plan
- Reset: assert `rst` for 2 cycles with `mem_write` = 1 → `ready` = 1 after reset with no request; `sram_we_n` = 1, `sram_dq_oe` = 0, `read_data` = 0.
- Store, W=2: `address` = 1028, `write_data` = 0xDEADBEEF →
  - Cycle 1: `sram_addr` = 2, `sram_dq_out` = 0xBEEF, `sram_we_n` = 0.
  - Cycle 2: `sram_we_n` = 1.
  - Cycle 3: `sram_addr` = 3, `sram_dq_out` = 0xDEAD, `sram_we_n` = 0.
  - `ready` is low for cycles 0..4 and high in cycle 5.
- Load, W=2: SRAM model returns 0xBEEF at address 2 and 0xDEAD at address 3; load from 1028 → `read_data` = 0xDEADBEEF in cycle 5, held until the next load completes.
- Read and write both set: `address` = 1024, `write_data` = 0x12345678, prior `read_data` = 0xDEADBEEF → two write strobes at `sram_addr` 0 and 1; `read_data` stays 0xDEADBEEF.
- Reset mid-load: assert `rst` in cycle 3 of a W=3 load → next cycle is IDLE, `read_data` = 0, no further strobes, `ready` = 1 with no request.
- W=4 back-to-back store then load at 1032 → `ready` is low for 9 cycles per access with exactly one `ready` = 1 cycle between them; the load returns the stored word.

Source files
------------

// File: rtl/sram_mem_stage.sv
// Memory-stage access unit: splits each 32-bit load/store into two 16-bit
// accesses on an external asynchronous SRAM and freezes the pipeline meanwhile.
module sram_mem_stage #(
  parameter int unsigned SRAM_WAIT = 2,
  parameter logic [31:0] ADDR_BASE = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  input  logic [15:0] sram_dq_in,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_e;

  localparam logic [3:0] LAST = 4'(SRAM_WAIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [16:0] wa_q, wa_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        we_n_q, we_n_d;

  logic        req;
  logic        last;
  logic        start;
  logic        in_access_d;
  logic [31:0] offset;
  logic        unused_bits;

  assign req    = mem_read | mem_write;
  assign last   = (cnt_q == LAST);
  assign start  = (state_q == S_IDLE) && req;
  assign offset = address - ADDR_BASE;
  assign unused_bits = ^{offset[31:19], offset[1:0]};

  // ready=1 means the EX/MEM register may advance on the next edge; when it
  // is 0 the register holds mem_read/mem_write/address/write_data stable.
  assign ready = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LOW;
          cnt_d   = 4'd0;
        end
      end
      S_LOW: begin
        if (last) begin
          state_d = S_HIGH;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (last) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_comb begin
    is_wr_d     = start ? mem_write  : is_wr_q;
    wa_d        = start ? offset[18:2] : wa_q;
    wdata_d     = start ? write_data : wdata_q;
    in_access_d = (state_d == S_LOW) || (state_d == S_HIGH);
    oe_d        = is_wr_d && in_access_d;
    we_n_d      = !(oe_d && (cnt_d != LAST));
    addr_d      = addr_q;
    dout_d      = dout_q;
    if (state_d == S_LOW) begin
      addr_d = {wa_d, 1'b0};
      if (is_wr_d) dout_d = wdata_d[15:0];
    end else if (state_d == S_HIGH) begin
      addr_d = {wa_d, 1'b1};
      if (is_wr_d) dout_d = wdata_d[31:16];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      is_wr_q <= 1'b0;
      wa_q    <= 17'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      addr_q  <= 18'd0;
      dout_q  <= 16'd0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      wa_q    <= wa_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
      if (!is_wr_q && last && (state_q == S_LOW))  rdata_q[15:0]  <= sram_dq_in;
      if (!is_wr_q && last && (state_q == S_HIGH)) rdata_q[31:16] <= sram_dq_in;
    end
  end

  assign read_data   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dout_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_mem_stage.sv
// Bench for sram_mem_stage: three instances (W=2,3,4) share stimulus; a mux
// selects which one the monitor watches against the expected queues.
module tb_sram_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  int          sel = 0;

  logic [31:0] rd0, rd1, rd2;
  logic        rdy0, rdy1, rdy2;
  logic [17:0] a0, a1, a2;
  logic [15:0] do0, do1, do2;
  logic        oe0, oe1, oe2;
  logic        we0, we1, we2;
  logic [15:0] di0, di1, di2;
  logic [1:0]  st0, st1, st2;

  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];
  logic [15:0] mem2 [64];

  sram_mem_stage #(.SRAM_WAIT(2), .ADDR_BASE(32'd1024)) u_w2 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(rd0), .ready(rdy0),
    .sram_addr(a0), .sram_dq_out(do0), .sram_dq_oe(oe0), .sram_we_n(we0),
    .sram_dq_in(di0), .dbg_state(st0));
  sram_mem_stage #(.SRAM_WAIT(3), .ADDR_BASE(32'd1024)) u_w3 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(rd1), .ready(rdy1),
    .sram_addr(a1), .sram_dq_out(do1), .sram_dq_oe(oe1), .sram_we_n(we1),
    .sram_dq_in(di1), .dbg_state(st1));
  sram_mem_stage #(.SRAM_WAIT(4), .ADDR_BASE(32'd1024)) u_w4 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(rd2), .ready(rdy2),
    .sram_addr(a2), .sram_dq_out(do2), .sram_dq_oe(oe2), .sram_we_n(we2),
    .sram_dq_in(di2), .dbg_state(st2));

  // Asynchronous SRAM models: combinational read, write while we_n is low.
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem0[i] = 16'h0;
      mem1[i] = 16'h0;
      mem2[i] = 16'h0;
    end
  end
  always @(posedge clk) if (!we0) mem0[a0[5:0]] <= do0;
  always @(posedge clk) if (!we1) mem1[a1[5:0]] <= do1;
  always @(posedge clk) if (!we2) mem2[a2[5:0]] <= do2;
  assign di0 = mem0[a0[5:0]];
  assign di1 = mem1[a1[5:0]];
  assign di2 = mem2[a2[5:0]];

  logic [31:0] m_rd;
  logic        m_ready, m_oe, m_we_n;
  logic [17:0] m_addr;
  logic [15:0] m_dout;
  always_comb begin
    m_rd = rd0; m_ready = rdy0; m_addr = a0; m_dout = do0; m_oe = oe0; m_we_n = we0;
    case (sel)
      1: begin m_rd = rd1; m_ready = rdy1; m_addr = a1; m_dout = do1; m_oe = oe1; m_we_n = we1; end
      2: begin m_rd = rd2; m_ready = rdy2; m_addr = a2; m_dout = do2; m_oe = oe2; m_we_n = we2; end
      default: ;
    endcase
  end

  logic [31:0] exp_q[$];
  int          frz_q[$];
  logic [33:0] strobe_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (W=%0d, t=%0t)", name, act, exp, sel + 2, $time);
    end
  endtask

  // Monitor: a ready 0->1 edge outside reset marks a completed access.
  int low_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      low_cnt = 0;
    end else if (!m_ready) begin
      low_cnt++;
    end else begin
      if (low_cnt != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(low_cnt), 32'd0);
        end else begin
          check("read_data", m_rd, exp_q.pop_front());
          check("freeze_cycles", 32'(low_cnt), 32'(frz_q.pop_front()));
        end
      end
      low_cnt = 0;
    end
    if (!rst && !m_we_n) begin
      if (strobe_q.size() == 0) begin
        check("extra_strobe_addr", 32'(m_addr), 32'hFFFF_FFFF);
      end else begin
        logic [33:0] e;
        e = strobe_q.pop_front();
        check("strobe_addr", 32'(m_addr), 32'(e[33:16]));
        check("strobe_data", 32'(m_dout), 32'(e[15:0]));
        check("strobe_oe", 32'(m_oe), 32'd1);
      end
    end
  end

  task automatic do_reset(input int s, input logic wr_hold);
    rst = 1'b1; mem_read = 1'b0; mem_write = wr_hold; sel = s;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues one access at the start of a cycle and returns just after the
  // edge that follows the first ready=1 cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd, input int w);
    logic [31:0] off;
    logic [16:0] wa;
    logic        done;
    off = a - 32'd1024;
    wa  = off[18:2];
    if (wr) begin
      for (int h = 0; h < 2; h++)
        for (int c = 0; c < w - 1; c++)
          strobe_q.push_back({wa, (h == 1), (h == 1) ? d[31:16] : d[15:0]});
    end
    exp_q.push_back(exp_rd);
    frz_q.push_back(2 * w + 1);
    mem_read = rd; mem_write = wr; address = a; write_data = d;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_ready) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input logic [31:0] exp_rd);
    @(negedge clk);
    check("idle_ready", 32'(m_ready), 32'd1);
    check("idle_we_n", 32'(m_we_n), 32'd1);
    check("idle_oe", 32'(m_oe), 32'd0);
    check("idle_read_data", m_rd, exp_rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a store request pending, then released with no request.
    do_reset(0, 1'b1);
    @(negedge clk);
    check("rst_addr", 32'(m_addr), 32'd0);
    check("rst_dout", 32'(m_dout), 32'd0);
    @(posedge clk);
    #1;
    check_quiet(32'd0);

    // W=2 store, load, both-set, readback.
    do_access(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 32'd0, 2);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEAD_BEEF, 2);
    idle(3);
    check_quiet(32'hDEAD_BEEF);
    do_access(1'b1, 1'b1, 32'd1024, 32'h1234_5678, 32'hDEAD_BEEF, 2);
    idle(1);
    check_quiet(32'hDEAD_BEEF);
    do_access(1'b1, 1'b0, 32'd1027, 32'h0, 32'h1234_5678, 2);
    idle(2);

    // W=3: store/load, then reset in cycle 3 of a load.
    do_reset(1, 1'b0);
    do_access(1'b0, 1'b1, 32'd1028, 32'hCAFE_F00D, 32'd0, 3);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, 32'hCAFE_F00D, 3);
    idle(1);
    mem_read = 1'b1; address = 32'd1028;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_quiet(32'd0);
    idle(6);
    check_quiet(32'd0);

    // W=4: back-to-back store then load.
    do_reset(2, 1'b0);
    do_access(1'b0, 1'b1, 32'd1032, 32'hA5C3_0FF0, 32'd0, 4);
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, 32'hA5C3_0FF0, 4);
    idle(4);
    check_quiet(32'hA5C3_0FF0);

    check("pending_strobes", 32'(strobe_q.size()), 32'd0);
    check("pending_responses", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
